// File: rtl/uart_cmd_rx_if.sv
// rtl/uart_cmd_rx_if.sv - received-byte strobe in, sequencer instruction strobe out
interface uart_cmd_rx_if;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic [7:0] o_inst;
  logic       o_inst_valid;

  modport master (output i_rx_data, i_rx_valid, input o_inst, o_inst_valid);
  modport slave  (input i_rx_data, i_rx_valid, output o_inst, o_inst_valid);
endinterface

// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - parses "XX"+CR/LF hex lines into instructions, buffers and issues them spaced out
module uart_cmd_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int ISSUE_GAP  = 16
) (
  input  logic         clk,
  input  logic         rst,
  uart_cmd_rx_if.slave bus,
  output logic         o_fifo_full,
  output logic         o_err,
  output logic [7:0]   o_err_cnt
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_LOAD = GW'(ISSUE_GAP - 1);

  localparam logic [1:0] S_HI   = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_END  = 2'd2;
  localparam logic [1:0] S_SKIP = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [3:0]    hi_nib, lo_nib;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    inst_q;
  logic          inst_valid_q;
  logic [7:0]    rx_byte;
  logic          is_hex, is_term;
  logic [3:0]    hex_val;
  logic          parse_err, push_req, push, pop, drop;

  assign rx_byte = bus.i_rx_data;
  assign is_term = (rx_byte == 8'h0D) || (rx_byte == 8'h0A);

  // Letters A-F/a-f share low nibbles 1..6, so +9 maps them to 10..15
  always_comb begin
    is_hex  = 1'b0;
    hex_val = 4'd0;
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      is_hex  = 1'b1;
      hex_val = rx_byte[3:0];
    end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                 (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
      is_hex  = 1'b1;
      hex_val = rx_byte[3:0] + 4'd9;
    end
  end

  always_comb begin
    state_nxt = state;
    parse_err = 1'b0;
    push_req  = 1'b0;
    if (bus.i_rx_valid) begin
      case (state)
        S_HI: begin
          if (is_hex) state_nxt = S_LO;
          else if (!is_term) begin
            parse_err = 1'b1;
            state_nxt = S_SKIP;
          end
        end
        S_LO: begin
          if (is_hex) state_nxt = S_END;
          else begin
            parse_err = 1'b1;
            state_nxt = is_term ? S_HI : S_SKIP;
          end
        end
        S_END: begin
          if (is_term) begin
            push_req  = 1'b1;
            state_nxt = S_HI;
          end else begin
            parse_err = 1'b1;
            state_nxt = S_SKIP;
          end
        end
        default: if (is_term) state_nxt = S_HI;
      endcase
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign pop       = (count != '0) && (gap_cnt == '0);
  assign push      = push_req && ((count != FULL_CNT) || pop);
  assign drop      = push_req && !push;
  assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {hi_nib, lo_nib};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_HI;
      hi_nib       <= 4'd0;
      lo_nib       <= 4'd0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      gap_cnt      <= '0;
      inst_q       <= 8'd0;
      inst_valid_q <= 1'b0;
      o_fifo_full  <= 1'b0;
      o_err        <= 1'b0;
      o_err_cnt    <= 8'd0;
    end else begin
      state <= state_nxt;
      if (bus.i_rx_valid && is_hex && state == S_HI) hi_nib <= hex_val;
      if (bus.i_rx_valid && is_hex && state == S_LO) lo_nib <= hex_val;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        inst_q  <= mem[rd_ptr];
        gap_cnt <= GAP_LOAD;
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
      count        <= count_nxt;
      inst_valid_q <= pop;
      o_fifo_full  <= (count_nxt == FULL_CNT);
      o_err        <= parse_err | drop;
      if ((parse_err | drop) && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
    end
  end

  assign bus.o_inst       = inst_q;
  assign bus.o_inst_valid = inst_valid_q;
endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

Receive-side command decoder for the board-level UART path. Consumes bytes from the UART receiver (`o_rx_data`/`o_rx_valid` of `uart_top`), parses ASCII hex command lines ("XX" + CR/LF) into 8-bit sequencer instructions, buffers them in a small FIFO, and issues them to `seq` as single-cycle `i_inst`/`i_inst_valid` pulses with a guaranteed minimum spacing. It is the host-driven counterpart to the switch/button instruction path, and it runs on the same clock and reset.

## Interface
- `FIFO_DEPTH`, default 4: decoded-instruction buffer depth; power of two, ≥2.
- `ISSUE_GAP`, default 16: minimum number of cycles between successive `o_inst_valid` pulses; ≥1.

- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset; synchronous, active-high.
- `i_rx_data`  in  8  received byte; valid only when `i_rx_valid`=1.
- `i_rx_valid`  in  1  one-cycle strobe per received byte.
- `o_inst`  out  8  instruction to the sequencer; holds the last issued value.
- `o_inst_valid`  out  1  one-cycle issue strobe.
- `o_fifo_full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `o_err`  out  1  one-cycle pulse per parse error or dropped command.
- `o_err_cnt`  out  8  error count; saturates at 255.

## Operation
- Hex digits: 0x30–0x39, 0x41–0x46, 0x61–0x66 (case-insensitive). Terminators: CR 0x0D, LF 0x0A.
- Parser FSM. Reset state is S_HI. A state is evaluated only on cycles where `i_rx_valid`=1.
  - S_HI: hex digit → latch it as the high nibble, go to S_LO. Terminator → ignored, stay in S_HI (tolerates CRLF and blank lines). Any other byte → error, go to S_SKIP.
  - S_LO: hex digit → latch it as the low nibble, go to S_END. Terminator → error, go to S_HI. Any other byte → error, go to S_SKIP.
  - S_END: terminator → push {hi,lo} into the FIFO, go to S_HI. Any other byte → error, go to S_SKIP.
  - S_SKIP: terminator → go to S_HI. Any other byte is discarded with no additional error.
- FIFO push while full and no pop in the same cycle: the command is dropped, `o_err` pulses, and the FIFO is unchanged.
- Push and pop in the same cycle: both complete. When the FIFO is full, the push is accepted because the pop frees the slot.
- Issue: a gap counter counts down to 0 and is 0 at reset. When the FIFO is non-empty and the gap counter is 0, the block pops the head entry, registers it onto `o_inst`, pulses `o_inst_valid`, and loads the gap counter with `ISSUE_GAP-1`.
- `o_err_cnt` increments by 1 on each `o_err` pulse and holds at 255.
- At most one error is generated per received byte.

## Timing
- Reset values: `o_inst`=0, `o_inst_valid`=0, `o_fifo_full`=0, `o_err`=0, `o_err_cnt`=0, FIFO empty, gap counter 0, FSM in S_HI.
- Reset asserted mid-line or mid-FIFO discards the partial nibbles and all buffered entries. No pulse is emitted during reset or in the cycle reset deasserts.
- Latency: terminator sampled at edge k writes the FIFO at edge k. With the FIFO previously empty and the gap counter at 0, `o_inst_valid` is high in the cycle following edge k+1. In that case the instruction issues 2 edges after its terminator.
- Spacing: if `o_inst_valid` is high in cycle t, the next pulse is no earlier than cycle t+`ISSUE_GAP`. With `ISSUE_GAP`=1, pulses may occur back to back.
- `o_err` is registered: it is high in the cycle after the offending byte is sampled.
- `o_fifo_full` is registered and reflects the occupancy after the current edge.
- Inputs require no handshake. Bytes may arrive on consecutive cycles, and every byte is consumed.

## Test plan
- "3A\r", with each byte sent once, spaced 10 cycles apart → exactly one `o_inst_valid` pulse with `o_inst`=0x3A, 2 edges after the CR; `o_err_cnt`=0.
- "c5\r\n7F\n" → pulses carrying 0xC5 then 0x7F, ≥16 cycles apart; the LF after CR produces no error.
- "3G\r41\r" then "4\r" → first line: one error (count 1), no issue; 0x41 then issues; the truncated "4\r" is an error (count 2), the FSM returns to S_HI, and a following "12\r" issues 0x12.
- `ISSUE_GAP`=64, six commands "01\r".."06\r" sent at one byte per cycle → 0x01..0x05 issued exactly 64 cycles apart, 0x06 dropped, `o_err_cnt`=1, `o_fifo_full` asserted while 4 entries are held.
- 300 bytes of 'Z' each followed by '\r' → `o_err_cnt` saturates at 255 and never wraps.
- Reset pulsed after "3" and with 2 entries queued → all outputs at reset values, no pulses; "55\r" afterwards issues 0x55 with the 2-edge latency.
